// File: rtl/board_io_ctrl_if.sv
// Display-load bus between the core and board_io_ctrl: hex nibbles, per-digit
// blanking and a load strobe.  Contract: DispLoad is a one-cycle qualifier, no ready.
interface board_io_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] DispValue;
    logic [NUM_DIGITS-1:0]   DispBlank;
    logic                    DispLoad;

    // DispValue/DispBlank are sampled on every clock edge where DispLoad is high;
    // the slave always accepts, so the master never waits.
    modport master (
        output DispValue,
        output DispBlank,
        output DispLoad
    );

    modport slave (
        input DispValue,
        input DispBlank,
        input DispLoad
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O front-end: button sync/debounce, switch sync, registered hex 7-seg drive.
// Optional macro LEADING_ZERO_BLANK_EN auto-blanks leading zero digits (digit 0 always shown).
module board_io_ctrl #(
    parameter int NUM_BTN        = 2,
    parameter int NUM_SW         = 10,
    parameter int NUM_DIGITS     = 6,
    parameter int DEBOUNCE_CYC   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    QClk,
    input  logic                    RstQnnnL,
    input  logic [NUM_BTN-1:0]      ButtonRaw,
    input  logic [NUM_SW-1:0]       SwitchRaw,
    board_io_ctrl_if.slave          disp,
    output logic [NUM_BTN-1:0]      BtnLevel,
    output logic [NUM_BTN-1:0]      BtnPress,
    output logic [NUM_BTN-1:0]      BtnRelease,
    output logic [NUM_SW-1:0]       SwSync,
    output logic [7*NUM_DIGITS-1:0] Seg7
);

    localparam int                    CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [7*NUM_DIGITS-1:0] SEG_DARK = {(7*NUM_DIGITS){SEG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Input synchronisers (buttons idle high at the pin, so reset to 1)
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_btn_meta;
    logic [NUM_BTN-1:0] r_btn_sync;
    logic [NUM_SW-1:0]  r_sw_meta;
    logic [NUM_SW-1:0]  r_sw_sync;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_btn_meta <= '1;
            r_btn_sync <= '1;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_btn_meta <= ButtonRaw;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= SwitchRaw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a button must disagree with its accepted level for
    // DEBOUNCE_CYC consecutive cycles before the level flips.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0]            w_pressed;
    logic [NUM_BTN-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_BTN-1:0]            r_btn_level;
    logic [NUM_BTN-1:0]            r_btn_press;
    logic [NUM_BTN-1:0]            r_btn_release;

    assign w_pressed = ~r_btn_sync;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_cnt         <= '0;
            r_btn_level   <= '0;
            r_btn_press   <= '0;
            r_btn_release <= '0;
        end else begin
            r_btn_press   <= '0;
            r_btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_pressed[i] == r_btn_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_btn_level[i]   <= w_pressed[i];
                    r_cnt[i]         <= '0;
                    r_btn_press[i]   <= w_pressed[i];
                    r_btn_release[i] <= ~w_pressed[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign BtnLevel   = r_btn_level;
    assign BtnPress   = r_btn_press;
    assign BtnRelease = r_btn_release;
    assign SwSync     = r_sw_sync;

    // ------------------------------------------------------------------
    // Display capture register; blank resets to all-ones so the panel is
    // dark until the core loads something.
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_blank;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_value <= '0;
            r_blank <= '1;
        end else if (disp.DispLoad) begin
            r_value <= disp.DispValue;
            r_blank <= disp.DispBlank;
        end
    end

    // Hex font, active-high, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Effective blanking and decode; polarity is applied last.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [7*NUM_DIGITS-1:0] w_seg_next;
    logic [6:0]              w_lit;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    w_hi_zero;
`endif

    always_comb begin
        w_blank    = r_blank;
        w_seg_next = '0;
        w_lit      = '0;
`ifdef LEADING_ZERO_BLANK_EN
        // Walk from the most significant digit down; a digit is a leading
        // zero while it and everything above it is zero.
        w_hi_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_hi_zero  = w_hi_zero & (r_value[4*i +: 4] == 4'h0);
            w_blank[i] = r_blank[i] | w_hi_zero;
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_lit = w_blank[i] ? 7'h00 : hex_font(r_value[4*i +: 4]);
            w_seg_next[7*i +: 7] = w_lit ^ {7{SEG_ACTIVE_LOW}};
        end
    end

    logic [7*NUM_DIGITS-1:0] r_seg;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_seg <= SEG_DARK;
        end else begin
            r_seg <= w_seg_next;
        end
    end

    assign Seg7 = r_seg;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with DEBOUNCE_CYC=4: reset, debounce, display, switches.
module tb_board_io_ctrl;

  localparam int NUM_BTN    = 2;
  localparam int NUM_SW     = 10;
  localparam int NUM_DIGITS = 6;
  localparam int DEB        = 4;

  // ---------------- clock / reset ----------------
  logic QClk = 1'b0;
  logic RstQnnnL = 1'b0;
  always #5 QClk = ~QClk;

  logic [NUM_BTN-1:0]      ButtonRaw;
  logic [NUM_SW-1:0]       SwitchRaw;
  logic [NUM_BTN-1:0]      BtnLevel;
  logic [NUM_BTN-1:0]      BtnPress;
  logic [NUM_BTN-1:0]      BtnRelease;
  logic [NUM_SW-1:0]       SwSync;
  logic [7*NUM_DIGITS-1:0] Seg7;

  board_io_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) disp_if ();

  board_io_ctrl #(
    .NUM_BTN(NUM_BTN),
    .NUM_SW(NUM_SW),
    .NUM_DIGITS(NUM_DIGITS),
    .DEBOUNCE_CYC(DEB),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .QClk(QClk),
    .RstQnnnL(RstQnnnL),
    .ButtonRaw(ButtonRaw),
    .SwitchRaw(SwitchRaw),
    .disp(disp_if),
    .BtnLevel(BtnLevel),
    .BtnPress(BtnPress),
    .BtnRelease(BtnRelease),
    .SwSync(SwSync),
    .Seg7(Seg7)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [6:0] dig(input int i);
    return Seg7[7*i +: 7];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_display(input logic [23:0] val, input logic [5:0] blank);
    @(negedge QClk);
    disp_if.DispValue = val;
    disp_if.DispBlank = blank;
    disp_if.DispLoad  = 1'b1;
    @(negedge QClk);
    disp_if.DispLoad  = 1'b0;
    @(negedge QClk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    int pulses;
    RstQnnnL = 1'b0;
    ButtonRaw = 2'b11;
    SwitchRaw = '0;
    disp_if.DispValue = 24'h0;
    disp_if.DispBlank = 6'h0;
    disp_if.DispLoad  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge QClk);
      ButtonRaw = ~ButtonRaw;
      SwitchRaw = ~SwitchRaw;
      disp_if.DispValue = 24'h123456 + 24'(k);
      disp_if.DispLoad  = ~disp_if.DispLoad;
    end
    @(negedge QClk);
    n_checks++;
    if (Seg7 !== 42'h3FF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_seg7: got %h expected %h", Seg7, 42'h3FF_FFFF_FFFF);
    end
    n_checks++;
    if ({BtnLevel, BtnPress, BtnRelease, SwSync} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b sw=%h expected all 0",
               BtnLevel, BtnPress, BtnRelease, SwSync);
    end
    ButtonRaw = 2'b11;
    SwitchRaw = '0;
    disp_if.DispLoad = 1'b0;
    RstQnnnL = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge QClk);
      pulses += $countones({BtnPress, BtnRelease});
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_release_pulse: got %0d pulses expected 0", pulses);
    end
    n_checks++;
    if (Seg7 !== 42'h3FF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_release_seg7: got %h expected all dark", Seg7);
    end
  endtask

  task automatic test_clean_press;
    int first_p, n_p, other, first_r, n_r;
    first_p = 0; n_p = 0; other = 0;
    @(negedge QClk);
    ButtonRaw[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge QClk);
      if (BtnPress[0]) begin
        n_p++;
        if (first_p == 0) first_p = k;
      end
      if (BtnPress[1] || BtnRelease != 2'b00) other++;
    end
    n_checks++;
    if (first_p !== 6 || n_p !== 1) begin
      n_fail++;
      $display("FAIL press0_timing: got first=%0d count=%0d expected first=6 count=1", first_p, n_p);
    end
    n_checks++;
    if (other !== 0) begin
      n_fail++;
      $display("FAIL press0_other: got %0d stray pulses expected 0", other);
    end
    n_checks++;
    if (BtnLevel !== 2'b01) begin
      n_fail++;
      $display("FAIL press0_level: got %b expected 01", BtnLevel);
    end
    first_r = 0; n_r = 0;
    ButtonRaw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge QClk);
      if (BtnRelease[0]) begin
        n_r++;
        if (first_r == 0) first_r = k;
      end
    end
    n_checks++;
    if (first_r !== 6 || n_r !== 1 || BtnLevel !== 2'b00) begin
      n_fail++;
      $display("FAIL release0: got first=%0d count=%0d lvl=%b expected first=6 count=1 lvl=00",
               first_r, n_r, BtnLevel);
    end
  endtask

  task automatic test_bounce;
    int first_p, n_p, first_r, n_r, k;
    logic pat[4];
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1;
    n_p = 0; first_p = 0;
    @(negedge QClk);
    for (int j = 0; j < 4; j++) begin
      ButtonRaw[1] = pat[j];
      @(negedge QClk);
      n_p += int'(BtnPress[1]);
    end
    ButtonRaw[1] = 1'b0;
    for (k = 1; k <= 12; k++) begin
      @(negedge QClk);
      if (BtnPress[1]) begin
        n_p++;
        if (first_p == 0) first_p = k;
      end
    end
    n_checks++;
    if (first_p !== 6 || n_p !== 1) begin
      n_fail++;
      $display("FAIL bounce_press: got first=%0d count=%0d expected first=6 count=1", first_p, n_p);
    end
    n_checks++;
    if (BtnLevel !== 2'b10) begin
      n_fail++;
      $display("FAIL bounce_level: got %b expected 10", BtnLevel);
    end
    n_r = 0; first_r = 0;
    ButtonRaw[1] = 1'b1;
    for (k = 1; k <= 12; k++) begin
      @(negedge QClk);
      if (BtnRelease[1]) begin
        n_r++;
        if (first_r == 0) first_r = k;
      end
    end
    n_checks++;
    if (first_r !== 6 || n_r !== 1) begin
      n_fail++;
      $display("FAIL bounce_release: got first=%0d count=%0d expected first=6 count=1", first_r, n_r);
    end
  endtask

  task automatic test_display;
    @(negedge QClk);
    disp_if.DispValue = 24'h12AB0F;
    disp_if.DispBlank = 6'b000000;
    disp_if.DispLoad  = 1'b1;
    @(negedge QClk);
    disp_if.DispLoad  = 1'b0;
    n_checks++;
    if (dig(0) !== 7'h7F) begin
      n_fail++;
      $display("FAIL disp_latency: digit0 got %h expected 7f one cycle after load", dig(0));
    end
    @(negedge QClk);
    n_checks++;
    if (dig(0) !== 7'h0E || dig(1) !== 7'h40 || dig(5) !== 7'h79) begin
      n_fail++;
      $display("FAIL disp_load: d0=%h d1=%h d5=%h expected 0e 40 79", dig(0), dig(1), dig(5));
    end
    n_checks++;
    if (dig(2) !== 7'h03 || dig(3) !== 7'h08 || dig(4) !== 7'h24) begin
      n_fail++;
      $display("FAIL disp_letters: d2=%h d3=%h d4=%h expected 03 08 24", dig(2), dig(3), dig(4));
    end
    load_display(24'h12AB0F, 6'b100000);
    n_checks++;
    if (dig(5) !== 7'h7F || dig(0) !== 7'h0E) begin
      n_fail++;
      $display("FAIL disp_blank: d5=%h d0=%h expected 7f 0e", dig(5), dig(0));
    end
    disp_if.DispValue = 24'h333333;
    disp_if.DispBlank = 6'b000000;
    repeat (3) @(negedge QClk);
    n_checks++;
    if (dig(0) !== 7'h0E || dig(5) !== 7'h7F) begin
      n_fail++;
      $display("FAIL disp_hold: d0=%h d5=%h expected 0e 7f", dig(0), dig(5));
    end
  endtask

  task automatic test_back_to_back;
    @(negedge QClk);
    disp_if.DispValue = 24'h000003;
    disp_if.DispBlank = 6'b000000;
    disp_if.DispLoad  = 1'b1;
    @(negedge QClk);
    disp_if.DispValue = 24'h000005;
    @(negedge QClk);
    disp_if.DispLoad  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge QClk);
      n_checks++;
      if (dig(0) !== 7'h12) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: digit0 got %h expected 12", k, dig(0));
      end
    end
  endtask

  task automatic test_switches;
    @(negedge QClk);
    SwitchRaw = 10'h2A5;
    @(negedge QClk);
    n_checks++;
    if (SwSync !== 10'h000) begin
      n_fail++;
      $display("FAIL sw_intermediate: got %h expected 000", SwSync);
    end
    @(negedge QClk);
    n_checks++;
    if (SwSync !== 10'h2A5) begin
      n_fail++;
      $display("FAIL sw_sync: got %h expected 2a5", SwSync);
    end
    SwitchRaw = 10'h15A;
    @(negedge QClk);
    n_checks++;
    if (SwSync !== 10'h2A5) begin
      n_fail++;
      $display("FAIL sw_hold: got %h expected 2a5", SwSync);
    end
    @(negedge QClk);
    n_checks++;
    if (SwSync !== 10'h15A) begin
      n_fail++;
      $display("FAIL sw_sync2: got %h expected 15a", SwSync);
    end
  endtask

  task automatic test_leading_zero;
    logic [6:0] exp_hi;
`ifdef LEADING_ZERO_BLANK_EN
    exp_hi = 7'h7F;
`else
    exp_hi = 7'h40;
`endif
    load_display(24'h000070, 6'b000000);
    n_checks++;
    if (dig(0) !== 7'h40 || dig(1) !== 7'h78) begin
      n_fail++;
      $display("FAIL lz_low: d0=%h d1=%h expected 40 78", dig(0), dig(1));
    end
    n_checks++;
    if (dig(2) !== exp_hi || dig(3) !== exp_hi || dig(4) !== exp_hi || dig(5) !== exp_hi) begin
      n_fail++;
      $display("FAIL lz_high: d2..d5=%h %h %h %h expected %h", dig(2), dig(3), dig(4), dig(5), exp_hi);
    end
    load_display(24'h000000, 6'b000000);
    n_checks++;
    if (dig(0) !== 7'h40 || dig(1) !== exp_hi || dig(5) !== exp_hi) begin
      n_fail++;
      $display("FAIL lz_zero: d0=%h d1=%h d5=%h expected 40 %h %h", dig(0), dig(1), dig(5), exp_hi, exp_hi);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    load_display(24'h0000AA, 6'b000000);
    ButtonRaw[0] = 1'b0;
    repeat (4) @(negedge QClk);
    RstQnnnL = 1'b0;
    #1;
    n_checks++;
    if (Seg7 !== 42'h3FF_FFFF_FFFF || BtnLevel !== 2'b00 || SwSync !== '0) begin
      n_fail++;
      $display("FAIL reset_async: seg=%h lvl=%b sw=%h expected dark 00 000", Seg7, BtnLevel, SwSync);
    end
    ButtonRaw = 2'b11;
    @(negedge QClk);
    RstQnnnL = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge QClk);
      pulses += $countones({BtnPress, BtnRelease, BtnLevel});
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_debounce: got %0d pulse/level cycles expected 0", pulses);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_display();
    test_back_to_back();
    test_switches();
    test_leading_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised board I/O front-end placed between the FPGA top level and the lotr core. It synchronises and debounces N active-low push-buttons and synchronises M slide switches. It drives a K-digit hex 7-segment display from a registered value with per-digit blanking. It replaces the direct pin-to-core wiring of the first-generation top, which had no synchronisation, no debouncing and a fixed digit count.

Parameters:
NUM_BTN, 2, number of push-buttons (active-low at the pin)
NUM_SW, 10, number of slide switches
NUM_DIGITS, 6, number of 7-segment digits
DEBOUNCE_CYC, 500, consecutive stable QClk cycles required to accept a button change (10 ms at 50 kHz); minimum 2
SEG_ACTIVE_LOW, 1, 1: segment lit when its bit is 0; 0: segment lit when its bit is 1

Ports:
QClk  input  1  block clock
RstQnnnL  input  1  asynchronous active-low reset
ButtonRaw  input  NUM_BTN  raw button pins, 0 = pressed
SwitchRaw  input  NUM_SW  raw switch pins
DispValue  input  4*NUM_DIGITS  hex nibbles; digit i = bits [4i+3:4i]
DispBlank  input  NUM_DIGITS  1 = force digit i dark
DispLoad  input  1  load DispValue/DispBlank into display register this cycle
BtnLevel  output  NUM_BTN  debounced state, 1 = pressed
BtnPress  output  NUM_BTN  one-cycle pulse on accepted press
BtnRelease  output  NUM_BTN  one-cycle pulse on accepted release
SwSync  output  NUM_SW  synchronised switches
Seg7  output  7*NUM_DIGITS  segments; digit i = bits [7i+6:7i], bit order g..a (bit 0 = a)

Behaviour:
- Reset (RstQnnnL low, async): button synchronisers = all 1s (released); switch synchronisers = 0; BtnLevel, BtnPress, BtnRelease, SwSync = 0; debounce counters = 0; value register = 0; blank register = all 1s; Seg7 = all digits dark (all 1s if SEG_ACTIVE_LOW, else all 0s).
- Synchronisers: two flops per input. SwSync lags SwitchRaw by 2 cycles. Switches are not debounced.
- Debounce, per button, independently. Let p = ~(synced button).
  - p == BtnLevel: counter cleared to 0.
  - p != BtnLevel: counter increments.
  - Counter reaches DEBOUNCE_CYC-1 while p != BtnLevel: next edge BtnLevel <= p, counter <= 0, and BtnPress (p=1) or BtnRelease (p=0) pulses for exactly 1 cycle.
  - Any glitch back to BtnLevel before acceptance restarts the count.
  - Counter width = $clog2(DEBOUNCE_CYC); saturation is never reached.
- Acceptance latency: raw edge to BtnLevel/pulse = 2 sync + DEBOUNCE_CYC cycles.
- Display register:
  - DispLoad=1 captures DispValue and DispBlank on the next edge.
  - Seg7 is registered: it reflects the new value 2 cycles after the DispLoad edge (capture + decode register).
  - DispLoad=0 holds the previous contents.
  - DispLoad asserted on consecutive cycles: last value wins; no queueing.
- Decode: standard hex font, 0-9 and A, b, C, d, E, F. Blanked digits are all segments off. Polarity is applied last per SEG_ACTIVE_LOW.
- Reset mid-debounce or mid-load: all state returns to reset values immediately; no pulse is generated on reset release.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit i (i > 0) is additionally blanked when its nibble and every higher digit's nibble are 0. Digit 0 is never auto-blanked, so value 0 shows a single "0". Explicit DispBlank still applies.
- Undefined: only DispBlank controls blanking.

Test Plan:
All scenarios use bench parameter DEBOUNCE_CYC=4.
- Reset check: hold RstQnnnL low, toggle all raw inputs -> Seg7 = 42'h3FF_FFFF_FFFF, all other outputs 0; release reset -> no BtnPress/BtnRelease pulse.
- Clean press: ButtonRaw[0] 1->0 and held -> BtnLevel[0]=1 and BtnPress[0]=1 for 1 cycle, exactly 6 cycles after the edge; BtnPress[1] stays 0.
- Bounce: ButtonRaw[1] pattern 0,1,0,1 (1 cycle each) then held 0 -> a single BtnPress[1], 6 cycles after the final falling edge; releasing gives a single BtnRelease[1].
- Display load: DispValue=24'h12AB0F, DispBlank=6'b000000, DispLoad pulse (SEG_ACTIVE_LOW=1) -> 2 cycles later digit0=7'h0E (F), digit1=7'h40 (0), digit5=7'h79 (1). Then DispBlank=6'b100000 with a load -> digit5=7'h7F.
- Switches: SwitchRaw=10'h2A5 -> SwSync=10'h2A5 after 2 cycles, with no intermediate value.
- LEADING_ZERO_BLANK_EN defined: DispValue=24'h000070 loaded -> digits 2-5 = 7'h7F, digit1=7'h78 (7), digit0=7'h40 (0). DispValue=0 -> only digit0 lit showing "0".
